// File: rtl/display_mode_scheduler_pkg.sv
// Shared types and default 500 Hz tick constants for the time-display sequencer.
package display_pkg;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        SHOW_USER = 2'd1,
        SHOW_CD   = 2'd2,
        ALERT     = 2'd3
    } disp_state_e;

    localparam int unsigned BLINK_HALF_DEF  = 250;
    localparam int unsigned ALERT_TICKS_DEF = 2500;
    localparam int unsigned IDLE_TICKS_DEF  = 15000;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/display_mode_scheduler_tick_timer.sv
// Loadable down-counter; tc_o flags the zero count while running and the counter auto-reloads.
module tick_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         run_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    assign tc_o = run_i && (cnt_q == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (run_i) begin
            cnt_q <= (cnt_q == '0) ? load_val_i : cnt_q - W'(1);
        end
    end

endmodule

// File: rtl/display_mode_scheduler.sv
// Chooses time source and page for the 4-digit display, with countdown-expiry alert blinking.
module display_mode_scheduler
    import display_pkg::*;
#(
    parameter int unsigned BLINK_HALF  = BLINK_HALF_DEF,
    parameter int unsigned ALERT_TICKS = ALERT_TICKS_DEF,
    parameter int unsigned IDLE_TICKS  = IDLE_TICKS_DEF
) (
    input  logic clk_500Hz,
    input  logic rst,
    input  logic power_on,
    input  logic cd_active,
    input  logic cd_done,
    input  logic btn_src,
    input  logic btn_page,
    output logic need_count_down,
    output logic switch1,
    output logic switch2,
    output logic en,
    output logic alert_active
);

    localparam int unsigned BW = cnt_w(BLINK_HALF);
    localparam int unsigned AW = cnt_w(ALERT_TICKS);
    localparam int unsigned IW = cnt_w(IDLE_TICKS);
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_HALF - 1);
    localparam logic [AW-1:0] ALERT_LOAD = AW'(ALERT_TICKS - 1);
    localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_TICKS - 1);

    disp_state_e   state_q, state_d;
    logic          sw1_q, sw1_d;
    logic          src_q, src_d;
    logic          ph_q, ph_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          need_cd_q, need_cd_d;
    logic          en_q, en_d;
    logic          alert_q, alert_d;
    logic          timer_load;
    logic          alert_tc, blink_tc;
    logic          btn_any;

    assign btn_any = btn_src | btn_page;

    // Blink timer down-counts from BLINK_HALF-1, matching an up-count 0..BLINK_HALF-1 wrap.
    tick_timer #(.W(AW)) u_alert_timer (
        .clk_i      (clk_500Hz),
        .rst_i      (rst),
        .clr_i      (!power_on),
        .load_i     (timer_load),
        .run_i      (state_q == ALERT),
        .load_val_i (ALERT_LOAD),
        .tc_o       (alert_tc)
    );

    tick_timer #(.W(BW)) u_blink_timer (
        .clk_i      (clk_500Hz),
        .rst_i      (rst),
        .clr_i      (!power_on),
        .load_i     (timer_load),
        .run_i      (state_q == ALERT),
        .load_val_i (BLINK_LOAD),
        .tc_o       (blink_tc)
    );

    always_comb begin
        state_d    = state_q;
        sw1_d      = sw1_q;
        src_d      = src_q;
        ph_d       = ph_q;
        idle_d     = idle_q;
        timer_load = 1'b0;
        if (!power_on) begin
            state_d = OFF;
            sw1_d   = 1'b0;
            src_d   = 1'b0;
            ph_d    = 1'b0;
            idle_d  = '0;
        end else if (state_q == OFF) begin
            state_d = SHOW_USER;
            sw1_d   = 1'b0;
        end else if (cd_done) begin
            state_d    = ALERT;
            timer_load = 1'b1;
            ph_d       = 1'b1;
            idle_d     = '0;
        end else begin
            case (state_q)
                SHOW_USER: begin
                    if (cd_active) state_d = SHOW_CD;
                    if (btn_src)   src_d   = ~src_q;
                end
                SHOW_CD: begin
                    if (!cd_active) state_d = SHOW_USER;
                end
                ALERT: begin
                    if (alert_tc || btn_any) state_d = SHOW_USER;
                    else if (blink_tc)       ph_d    = ~ph_q;
                end
                default: state_d = OFF;
            endcase
            if (state_q == SHOW_USER || state_q == SHOW_CD) begin
                if (btn_any) begin
                    idle_d = '0;
                    if (btn_page) sw1_d = ~sw1_q;
                end else if (idle_q == IDLE_MAX) begin
                    if (sw1_q) begin
                        sw1_d  = 1'b0;
                        idle_d = '0;
                    end
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end
        end
        need_cd_d = (state_d == SHOW_CD) || (state_d == ALERT);
        alert_d   = (state_d == ALERT);
        en_d      = (state_d == ALERT) ? ph_d : (state_d != OFF);
    end

    always_ff @(posedge clk_500Hz or posedge rst) begin
        if (rst) begin
            state_q   <= OFF;
            sw1_q     <= 1'b0;
            src_q     <= 1'b0;
            ph_q      <= 1'b0;
            idle_q    <= '0;
            need_cd_q <= 1'b0;
            en_q      <= 1'b0;
            alert_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sw1_q     <= sw1_d;
            src_q     <= src_d;
            ph_q      <= ph_d;
            idle_q    <= idle_d;
            need_cd_q <= need_cd_d;
            en_q      <= en_d;
            alert_q   <= alert_d;
        end
    end

    assign need_count_down = need_cd_q;
    assign switch1         = sw1_q;
    assign switch2         = src_q;
    assign en              = en_q;
    assign alert_active    = alert_q;

endmodule

// File: tb/tb_display_mode_scheduler.sv
// Directed bench for display_mode_scheduler; outputs compared as {need_count_down,switch1,switch2,en,alert_active}.
module tb_display_mode_scheduler;

    logic clk = 1'b0;
    logic rst, power_on, cd_active, cd_done, btn_src, btn_page;
    logic need_count_down, switch1, switch2, en, alert_active;
    logic [4:0] outs;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign outs = {need_count_down, switch1, switch2, en, alert_active};

    display_mode_scheduler #(
        .BLINK_HALF  (250),
        .ALERT_TICKS (2500),
        .IDLE_TICKS  (15000)
    ) dut (
        .clk_500Hz       (clk),
        .rst             (rst),
        .power_on        (power_on),
        .cd_active       (cd_active),
        .cd_done         (cd_done),
        .btn_src         (btn_src),
        .btn_page        (btn_page),
        .need_count_down (need_count_down),
        .switch1         (switch1),
        .switch2         (switch2),
        .en              (en),
        .alert_active    (alert_active)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        power_on = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        vectors++; if (outs !== 5'b00010) begin miscompares++; $display("FAIL power_up: got %b want %b", outs, 5'b00010); end
        cd_done = 1'b1; step(1); cd_done = 1'b0;
        vectors++; if (outs !== 5'b10011) begin miscompares++; $display("FAIL enter_alert: got %b want %b", outs, 5'b10011); end
        step(10);
        #2 rst = 1'b1;
        #1;
        vectors++; if (outs !== 5'b00000) begin miscompares++; $display("FAIL async_reset: got %b want %b", outs, 5'b00000); end
        step(1);
        rst = 1'b0;
        step(1);
        vectors++; if (outs !== 5'b00010) begin miscompares++; $display("FAIL reset_release: got %b want %b", outs, 5'b00010); end
    endtask

    task automatic test_user_toggle;
        btn_src = 1'b1; step(1); btn_src = 1'b0;
        vectors++; if (outs !== 5'b00110) begin miscompares++; $display("FAIL src_toggle: got %b want %b", outs, 5'b00110); end
        step(3);
        vectors++; if (outs !== 5'b00110) begin miscompares++; $display("FAIL src_hold: got %b want %b", outs, 5'b00110); end
        btn_page = 1'b1; step(1); btn_page = 1'b0;
        vectors++; if (outs !== 5'b01110) begin miscompares++; $display("FAIL page_toggle: got %b want %b", outs, 5'b01110); end
        btn_src = 1'b1; btn_page = 1'b1; step(1); btn_src = 1'b0; btn_page = 1'b0;
        vectors++; if (outs !== 5'b00010) begin miscompares++; $display("FAIL both_buttons: got %b want %b", outs, 5'b00010); end
        btn_src = 1'b1; step(1); btn_src = 1'b0;
        vectors++; if (outs !== 5'b00110) begin miscompares++; $display("FAIL src_again: got %b want %b", outs, 5'b00110); end
    endtask

    task automatic test_countdown;
        cd_active = 1'b1; step(1);
        vectors++; if (outs !== 5'b10110) begin miscompares++; $display("FAIL show_cd: got %b want %b", outs, 5'b10110); end
        btn_src = 1'b1; step(1); btn_src = 1'b0;
        vectors++; if (outs !== 5'b10110) begin miscompares++; $display("FAIL cd_src_ignored: got %b want %b", outs, 5'b10110); end
        btn_page = 1'b1; step(1); btn_page = 1'b0;
        vectors++; if (outs !== 5'b11110) begin miscompares++; $display("FAIL cd_page_toggle: got %b want %b", outs, 5'b11110); end
        btn_page = 1'b1; step(1); btn_page = 1'b0;
        vectors++; if (outs !== 5'b10110) begin miscompares++; $display("FAIL cd_page_back: got %b want %b", outs, 5'b10110); end
        cd_active = 1'b0; step(1);
        vectors++; if (outs !== 5'b00110) begin miscompares++; $display("FAIL cd_cancel: got %b want %b", outs, 5'b00110); end
    endtask

    task automatic test_alert_timeout;
        cd_active = 1'b1; step(1);
        cd_done = 1'b1; cd_active = 1'b0; step(1); cd_done = 1'b0;
        vectors++; if (outs !== 5'b10111) begin miscompares++; $display("FAIL alert_t0: got %b want %b", outs, 5'b10111); end
        step(249);
        vectors++; if (outs !== 5'b10111) begin miscompares++; $display("FAIL blink_t249: got %b want %b", outs, 5'b10111); end
        step(1);
        vectors++; if (outs !== 5'b10101) begin miscompares++; $display("FAIL blink_t250: got %b want %b", outs, 5'b10101); end
        step(249);
        vectors++; if (outs !== 5'b10101) begin miscompares++; $display("FAIL blink_t499: got %b want %b", outs, 5'b10101); end
        step(1);
        vectors++; if (outs !== 5'b10111) begin miscompares++; $display("FAIL blink_t500: got %b want %b", outs, 5'b10111); end
        step(1999);
        vectors++; if (outs !== 5'b10101) begin miscompares++; $display("FAIL alert_t2499: got %b want %b", outs, 5'b10101); end
        step(1);
        vectors++; if (outs !== 5'b00110) begin miscompares++; $display("FAIL alert_expire: got %b want %b", outs, 5'b00110); end
    endtask

    task automatic test_alert_ack;
        btn_page = 1'b1; step(1); btn_page = 1'b0;
        cd_done = 1'b1; step(1); cd_done = 1'b0;
        vectors++; if (outs !== 5'b11111) begin miscompares++; $display("FAIL ack_alert_t0: got %b want %b", outs, 5'b11111); end
        step(99);
        btn_page = 1'b1; step(1); btn_page = 1'b0;
        vectors++; if (outs !== 5'b01110) begin miscompares++; $display("FAIL ack_consumed: got %b want %b", outs, 5'b01110); end
        cd_done = 1'b1; step(1); cd_done = 1'b0;
        step(1999);
        cd_done = 1'b1; step(1); cd_done = 1'b0;
        vectors++; if (outs !== 5'b11111) begin miscompares++; $display("FAIL restart_t2000: got %b want %b", outs, 5'b11111); end
        step(500);
        vectors++; if (outs !== 5'b11111) begin miscompares++; $display("FAIL restart_t2500: got %b want %b", outs, 5'b11111); end
        step(1999);
        vectors++; if (outs !== 5'b11101) begin miscompares++; $display("FAIL restart_t4499: got %b want %b", outs, 5'b11101); end
        step(1);
        vectors++; if (outs !== 5'b01110) begin miscompares++; $display("FAIL restart_expire: got %b want %b", outs, 5'b01110); end
    endtask

    task automatic test_idle_revert;
        btn_page = 1'b1; step(1); btn_page = 1'b0;
        btn_page = 1'b1; step(1); btn_page = 1'b0;
        step(14999);
        vectors++; if (outs !== 5'b01110) begin miscompares++; $display("FAIL idle_t14999: got %b want %b", outs, 5'b01110); end
        step(1);
        vectors++; if (outs !== 5'b00110) begin miscompares++; $display("FAIL idle_t15000: got %b want %b", outs, 5'b00110); end
        btn_page = 1'b1; step(1); btn_page = 1'b0;
        step(5000);
        power_on = 1'b0; step(1);
        vectors++; if (outs !== 5'b00000) begin miscompares++; $display("FAIL power_off: got %b want %b", outs, 5'b00000); end
        btn_src = 1'b1; btn_page = 1'b1; step(1); btn_src = 1'b0; btn_page = 1'b0;
        step(5);
        vectors++; if (outs !== 5'b00000) begin miscompares++; $display("FAIL off_buttons: got %b want %b", outs, 5'b00000); end
        power_on = 1'b1; step(1);
        vectors++; if (outs !== 5'b00010) begin miscompares++; $display("FAIL repower: got %b want %b", outs, 5'b00010); end
    endtask

    task automatic test_back_to_back;
        cd_active = 1'b1; cd_done = 1'b1; step(1); cd_done = 1'b0; cd_active = 1'b0;
        vectors++; if (outs !== 5'b10011) begin miscompares++; $display("FAIL done_beats_active: got %b want %b", outs, 5'b10011); end
        btn_src = 1'b1; step(1); btn_src = 1'b0;
        vectors++; if (outs !== 5'b00010) begin miscompares++; $display("FAIL src_ack_consumed: got %b want %b", outs, 5'b00010); end
    endtask

    initial begin
        rst = 1'b1; power_on = 1'b0; cd_active = 1'b0; cd_done = 1'b0;
        btn_src = 1'b0; btn_page = 1'b0;
        #1;
        test_reset;
        test_user_toggle;
        test_countdown;
        test_alert_timeout;
        test_alert_ack;
        test_idle_revert;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
